// File: rtl/matrix_scrub_ctrl_if.sv
// Byte-stream handshake bundle for the matrix scrub controller:
// upstream element load channel and downstream element output channel.
interface matrix_scrub_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_scrub_ctrl.sv
// 4x4 matrix 2-D parity scrub controller: load, encode, hold/inject, check, correct, stream out.
// Optional MATRIX_ERR_CNT_EN adds saturating corrected/uncorrectable event counters.
module matrix_scrub_ctrl #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_scrub_ctrl_if.slave bus,
    input  logic               inj_en,
    input  logic [3:0]         inj_addr,
    input  logic [DW-1:0]      inj_mask,
    input  logic               check_start,
    output logic               busy,
    output logic               status_vld,
    output logic [1:0]         status,
    output logic [1:0]         err_row,
    output logic [1:0]         err_col
`ifdef MATRIX_ERR_CNT_EN
    ,
    output logic [15:0]        corr_cnt,
    output logic [15:0]        uncorr_cnt
`endif
);
    typedef enum logic [2:0] {
        S_LOAD, S_ENCODE, S_HOLD, S_CHECK, S_DECIDE, S_CORRECT, S_OUT
    } state_t;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;

    state_t        state_reg, state_next;
    logic [DW-1:0] mem_reg  [16];
    logic [DW-1:0] rpar_reg [4];
    logic [DW-1:0] cpar_reg [4];
    logic [DW-1:0] rs_reg   [4];
    logic [DW-1:0] cs_reg   [4];
    logic [3:0]    idx_reg;
    logic [1:0]    row_reg;
    logic [1:0]    status_reg, err_row_reg, err_col_reg;
    logic          status_vld_reg;

    logic          in_ready_c, out_valid_c, out_last_c, busy_c;
    logic [DW-1:0] out_data_c;
    logic          in_fire, out_fire;
    logic [DW-1:0] row_xor  [4];
    logic [DW-1:0] cur_elem [4];
    logic [2:0]    rs_nz_cnt, cs_nz_cnt;
    logic [1:0]    rs_idx, cs_idx, dec_status;

    assign in_fire  = bus.in_valid && in_ready_c;
    assign out_fire = out_valid_c && bus.out_ready;

    // Full row XORs and the four elements of the row currently being swept.
    for (genvar gi = 0; gi < 4; gi++) begin : g_par
        assign row_xor[gi]  = mem_reg[4*gi] ^ mem_reg[4*gi+1] ^ mem_reg[4*gi+2] ^ mem_reg[4*gi+3];
        assign cur_elem[gi] = mem_reg[{row_reg, 2'(gi)}];
    end

    always_comb begin
        rs_nz_cnt  = 3'd0;
        cs_nz_cnt  = 3'd0;
        rs_idx     = 2'd0;
        cs_idx     = 2'd0;
        dec_status = ST_UNCORR;
        for (int i = 0; i < 4; i++) begin
            if (rs_reg[i] != '0) begin
                rs_nz_cnt = rs_nz_cnt + 3'd1;
                rs_idx    = 2'(i);
            end
            if (cs_reg[i] != '0) begin
                cs_nz_cnt = cs_nz_cnt + 3'd1;
                cs_idx    = 2'(i);
            end
        end
        if (rs_nz_cnt == 3'd0 && cs_nz_cnt == 3'd0)
            dec_status = ST_CLEAN;
        else if (rs_nz_cnt == 3'd1 && cs_nz_cnt == 3'd1 && rs_reg[rs_idx] == cs_reg[cs_idx])
            dec_status = ST_CORR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_LOAD;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD:    if (in_fire && idx_reg == 4'd15) state_next = S_ENCODE;
            S_ENCODE:  if (row_reg == 2'd3) state_next = S_HOLD;
            S_HOLD:    if (check_start) state_next = S_CHECK;
            S_CHECK:   if (row_reg == 2'd3) state_next = S_DECIDE;
            S_DECIDE:  state_next = S_CORRECT;
            S_CORRECT: state_next = S_OUT;
            S_OUT:     if (out_fire && idx_reg == 4'd15) state_next = S_LOAD;
            default:   state_next = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready_c  = (state_reg == S_LOAD);
        out_valid_c = (state_reg == S_OUT);
        out_last_c  = (state_reg == S_OUT) && (idx_reg == 4'd15);
        out_data_c  = (state_reg == S_OUT) ? mem_reg[idx_reg] : '0;
        busy_c      = (state_reg != S_LOAD) && (state_reg != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem_reg[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                rpar_reg[i] <= '0;
                cpar_reg[i] <= '0;
                rs_reg[i]   <= '0;
                cs_reg[i]   <= '0;
            end
            idx_reg        <= '0;
            row_reg        <= '0;
            status_reg     <= ST_CLEAN;
            err_row_reg    <= '0;
            err_col_reg    <= '0;
            status_vld_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: if (in_fire) begin
                    mem_reg[idx_reg] <= bus.in_data;
                    idx_reg          <= idx_reg + 4'd1;
                    status_vld_reg   <= 1'b0;
                    status_reg       <= ST_CLEAN;
                    err_row_reg      <= '0;
                    err_col_reg      <= '0;
                end
                S_ENCODE: begin
                    rpar_reg[row_reg] <= row_xor[row_reg];
                    for (int c = 0; c < 4; c++)
                        cpar_reg[c] <= ((row_reg == 2'd0) ? '0 : cpar_reg[c]) ^ cur_elem[c];
                    row_reg <= row_reg + 2'd1;
                end
                S_HOLD: if (inj_en) mem_reg[inj_addr] <= mem_reg[inj_addr] ^ inj_mask;
                // Seeding the column syndromes with the stored parity leaves stored^recomputed after row 3.
                S_CHECK: begin
                    rs_reg[row_reg] <= rpar_reg[row_reg] ^ row_xor[row_reg];
                    for (int c = 0; c < 4; c++)
                        cs_reg[c] <= ((row_reg == 2'd0) ? cpar_reg[c] : cs_reg[c]) ^ cur_elem[c];
                    row_reg <= row_reg + 2'd1;
                end
                S_DECIDE: begin
                    status_reg     <= dec_status;
                    status_vld_reg <= 1'b1;
                    err_row_reg    <= (dec_status == ST_CORR) ? rs_idx : 2'd0;
                    err_col_reg    <= (dec_status == ST_CORR) ? cs_idx : 2'd0;
                end
                S_CORRECT: if (status_reg == ST_CORR)
                    mem_reg[{err_row_reg, err_col_reg}] <= mem_reg[{err_row_reg, err_col_reg}] ^ rs_reg[err_row_reg];
                S_OUT: if (out_fire) idx_reg <= idx_reg + 4'd1;
                default: ;
            endcase
        end
    end

`ifdef MATRIX_ERR_CNT_EN
    logic [15:0] corr_cnt_reg, uncorr_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_reg   <= '0;
            uncorr_cnt_reg <= '0;
        end else if (state_reg == S_DECIDE) begin
            if (dec_status == ST_CORR && corr_cnt_reg != 16'hFFFF)
                corr_cnt_reg <= corr_cnt_reg + 16'd1;
            if (dec_status == ST_UNCORR && uncorr_cnt_reg != 16'hFFFF)
                uncorr_cnt_reg <= uncorr_cnt_reg + 16'd1;
        end
    end

    assign corr_cnt   = corr_cnt_reg;
    assign uncorr_cnt = uncorr_cnt_reg;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;
    assign busy          = busy_c;
    assign status_vld    = status_vld_reg;
    assign status        = status_reg;
    assign err_row       = err_row_reg;
    assign err_col       = err_col_reg;
endmodule

// File: doc/matrix_scrub_ctrl.md
Name: matrix_scrub_ctrl

Overview:
- Sequencing controller for the 4x4 byte-matrix fault-tolerance datapath.
- Loads a 16-element matrix serially and encodes 2-D parity: one check word per row (XOR across the row) and one per column (XOR down the column).
- Holds the protected matrix, accepts fault injection for test, and on command runs a check/locate/correct pass.
- Streams the (corrected) matrix out and reports status. Sits between the row-level correction datapath and the upstream/downstream byte streams.

Parameters:
DW, 8, element width in bits; all matrix, parity and syndrome words are DW wide.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input element valid
in_data  input  DW  input element, row-major order (addr 0 = r0c0 ... addr 15 = r3c3)
in_ready  output  1  controller accepting elements
inj_en  input  1  fault-injection strobe
inj_addr  input  4  element to corrupt (row = addr[3:2], col = addr[1:0])
inj_mask  input  DW  XOR mask applied to the stored element
check_start  input  1  single-cycle pulse that starts a check pass
out_valid  output  1  output element valid
out_data  output  DW  output element, row-major order
out_last  output  1  marks element 15
out_ready  input  1  downstream accepting
busy  output  1  high in ENCODE, CHECK, DECIDE, CORRECT, OUT
status_vld  output  1  status fields valid
status  output  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused
err_row  output  2  row of the corrected element (0 unless status = 01)
err_col  output  2  column of the corrected element (0 unless status = 01)

Behaviour:
- Reset is async and clears everything: array, parity registers and the element index are zeroed; state = LOAD; in_ready = 1; all other outputs = 0. Reset asserted mid-pass discards the pass.
- States: LOAD, ENCODE, HOLD, CHECK, DECIDE, CORRECT, OUT.
- LOAD:
  - in_ready = 1.
  - Each in_valid&in_ready handshake writes one element at the index, then the index increments.
  - On the 16th handshake: index wraps to 0, in_ready drops next cycle, go to ENCODE.
  - status_vld clears on the first handshake.
- ENCODE: 4 cycles, one row per cycle. Stores the row parity; accumulates column parity. Then HOLD.
- HOLD:
  - inj_en XORs inj_mask into element inj_addr in one cycle. The parity words are not changed.
  - check_start goes to CHECK. If inj_en and check_start arrive in the same cycle, the injection is applied first and the check sees it.
  - inj_en is ignored in every state except HOLD. check_start is ignored in every state except HOLD. in_valid is ignored in every state except LOAD.
- CHECK: 4 cycles. Recompute each row and column XOR.
  - Row syndrome rs[r] = stored row parity XOR recomputed.
  - Column syndrome cs[c] = stored column parity XOR recomputed.
- DECIDE: 1 cycle.
  - All syndromes zero -> status 00.
  - Exactly one nonzero rs[r], exactly one nonzero cs[c], and rs[r] == cs[c] -> status 01; err_row = r, err_col = c.
  - Anything else -> status 10.
  - status_vld is set at the end of DECIDE and holds until the next LOAD handshake.
- CORRECT: always 1 cycle, so latency is fixed. If status = 01, element[r][c] ^= rs[r].
- OUT:
  - Present elements 0..15 in order; out_valid = 1.
  - Advance only on out_valid&out_ready; hold data stable under backpressure.
  - out_last = 1 with element 15.
  - After the element-15 handshake: go to LOAD, in_ready = 1 on the next cycle.
  - An uncorrectable matrix is output as stored.
- Latency: check_start accepted at cycle 0 -> CHECK cycles 1-4, DECIDE 5, CORRECT 6, out_valid first high in cycle 7.
- From the 16th load handshake to entering HOLD: 4 ENCODE cycles.

Optional Feature:
- Macro MATRIX_ERR_CNT_EN.
- When defined:
  - Adds outputs corr_cnt [15:0] and uncorr_cnt [15:0].
  - Each increments by 1 at the end of a DECIDE that yields status 01 or 10 respectively.
  - Both saturate at 16'hFFFF and are cleared only by rst_n.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Clean pass: load 0x01..0x10, check_start -> status 00, status_vld = 1, out_valid first at cycle 7, outputs 0x01..0x10, out_last on 0x10, in_ready = 1 after.
- Single error: inj_addr 5, mask 0x20 (element 0x06 -> 0x26), check -> status 01, err_row 1, err_col 1, output element 5 = 0x06.
- Double error: inj_addr 0 and 15, mask 0x01 each -> status 10, output element 0 = 0x00, element 15 = 0x11, counters (if enabled) uncorr_cnt = 1.
- Backpressure: out_ready low for 3 cycles at element 7 -> out_data holds 0x08 with out_valid high; no element skipped or duplicated; 16 handshakes total.
- Simultaneous inj_en + check_start in HOLD (addr 10, mask 0x80) -> status 01, err_row 2, err_col 2; check_start during OUT ignored.
- rst_n low during OUT element 4 -> immediately out_valid 0, in_ready 1, status_vld 0; fresh load/check of 0x01..0x10 gives status 00.
